// File: rtl/alarm_timekeeper_pkg.sv
// Shared types for the alarm timekeeper: BCD time layout, write-target codes
// and the countdown timer state encoding.
package alarm_timekeeper_pkg;

  localparam int DIGIT_W = 4;
  localparam int BCD_W   = 6 * DIGIT_W;

  // HHMMSS with the hour tens digit in the most significant nibble
  typedef struct packed {
    logic [DIGIT_W-1:0] h_hi;
    logic [DIGIT_W-1:0] h_lo;
    logic [DIGIT_W-1:0] m_hi;
    logic [DIGIT_W-1:0] m_lo;
    logic [DIGIT_W-1:0] s_hi;
    logic [DIGIT_W-1:0] s_lo;
  } hms_t;

  localparam logic [3:0] TGT_TIME   = 4'd0;
  localparam logic [3:0] TGT_TIMER  = 4'd1;
  localparam logic [3:0] TGT_ALARM0 = 4'd2;

  typedef enum logic [1:0] {
    T_IDLE = 2'd0,
    T_RUN  = 2'd1,
    T_DONE = 2'd2
  } timer_state_e;

endpackage

// File: rtl/alarm_timekeeper_bcd_hms_step.sv
// One-second BCD step (up or down) of an HHMMSS value, plus a range check of a
// candidate load value. 23:59:59 wraps up to 00:00:00 and back down again.
module bcd_hms_step
  import alarm_timekeeper_pkg::*;
(
  input  logic [BCD_W-1:0] val,
  input  logic             down,
  input  logic [BCD_W-1:0] chk,
  output logic [BCD_W-1:0] nxt,
  output logic             chk_ok
);

  hms_t v;
  hms_t c;
  hms_t r;

  assign v = val;
  assign c = chk;

  always_comb begin
    r = v;
    if (!down) begin
      if (v.s_lo != 4'd9) r.s_lo = v.s_lo + 4'd1;
      else begin
        r.s_lo = 4'd0;
        if (v.s_hi != 4'd5) r.s_hi = v.s_hi + 4'd1;
        else begin
          r.s_hi = 4'd0;
          if (v.m_lo != 4'd9) r.m_lo = v.m_lo + 4'd1;
          else begin
            r.m_lo = 4'd0;
            if (v.m_hi != 4'd5) r.m_hi = v.m_hi + 4'd1;
            else begin
              r.m_hi = 4'd0;
              if (v.h_hi == 4'd2 && v.h_lo == 4'd3) begin
                r.h_hi = 4'd0;
                r.h_lo = 4'd0;
              end else if (v.h_lo == 4'd9) begin
                r.h_lo = 4'd0;
                r.h_hi = v.h_hi + 4'd1;
              end else begin
                r.h_lo = v.h_lo + 4'd1;
              end
            end
          end
        end
      end
    end else begin
      if (v.s_lo != 4'd0) r.s_lo = v.s_lo - 4'd1;
      else begin
        r.s_lo = 4'd9;
        if (v.s_hi != 4'd0) r.s_hi = v.s_hi - 4'd1;
        else begin
          r.s_hi = 4'd5;
          if (v.m_lo != 4'd0) r.m_lo = v.m_lo - 4'd1;
          else begin
            r.m_lo = 4'd9;
            if (v.m_hi != 4'd0) r.m_hi = v.m_hi - 4'd1;
            else begin
              r.m_hi = 4'd5;
              if (v.h_lo != 4'd0) r.h_lo = v.h_lo - 4'd1;
              else if (v.h_hi != 4'd0) begin
                r.h_lo = 4'd9;
                r.h_hi = v.h_hi - 4'd1;
              end else begin
                r.h_hi = 4'd2;
                r.h_lo = 4'd3;
              end
            end
          end
        end
      end
    end
  end

  assign nxt = r;

  assign chk_ok = ((c.h_hi < 4'd2 && c.h_lo <= 4'd9) || (c.h_hi == 4'd2 && c.h_lo <= 4'd3))
               && (c.m_hi <= 4'd5) && (c.m_lo <= 4'd9)
               && (c.s_hi <= 4'd5) && (c.s_lo <= 4'd9);

endmodule

// File: rtl/alarm_timekeeper.sv
// Real-time clock with BCD time of day, alarm channels, a countdown timer,
// a timed buzzer and a registered 12/24-hour display view.
module alarm_timekeeper
  import alarm_timekeeper_pkg::*;
#(
  parameter int TICK_DIV   = 12000000,
  parameter int NUM_ALARMS = 4,
  parameter int BUZZ_SECS  = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [3:0]            wr_target,
  input  logic [BCD_W-1:0]      wr_bcd,
  input  logic                  mode12,
  input  logic [NUM_ALARMS-1:0] alarm_en,
  input  logic                  timer_start,
  input  logic                  ack,
  output logic [BCD_W-1:0]      time_bcd,
  output logic [BCD_W-1:0]      disp_bcd,
  output logic                  pm,
  output logic [BCD_W-1:0]      timer_bcd,
  output logic                  sec_tick,
  output logic                  timer_done,
  output logic                  wr_err,
  output logic                  buzzer,
  output logic [NUM_ALARMS-1:0] alarm_hit
);

  localparam int               DIV_W     = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(TICK_DIV - 1);
  localparam logic [7:0]       BUZZ_LOAD = 8'(BUZZ_SECS);

  logic [DIV_W-1:0]      div_cnt;
  logic [BCD_W-1:0]      alarm_q [NUM_ALARMS];
  timer_state_e          t_state;
  logic [7:0]            buzz_cnt;

  logic [BCD_W-1:0]      time_inc;
  logic [BCD_W-1:0]      timer_dec;
  logic                  time_chk_ok;
  logic                  timer_chk_ok;
  logic [BCD_W-1:0]      time_nxt;
  logic                  time_chg;
  logic                  tgt_exists;
  logic                  time_wr;
  logic                  timer_wr;
  logic                  alarm_wr;
  logic                  timer_hit;
  logic                  buzz_evt;
  logic [NUM_ALARMS-1:0] alarm_match;
  logic [BCD_W:0]        disp_nxt;

  // Maps a 24-hour value to {pm, display}; hours 00 and 12 both show as 12.
  function automatic logic [BCD_W:0] fmt_disp(input logic [BCD_W-1:0] t, input logic m12);
    hms_t       v;
    logic [4:0] h;
    logic [4:0] h12;
    logic       pm_f;
    v    = t;
    h    = 5'(v.h_hi) * 5'd10 + 5'(v.h_lo);
    pm_f = 1'b0;
    if (m12) begin
      pm_f = (h >= 5'd12);
      if (h == 5'd0)      h12 = 5'd12;
      else if (h > 5'd12) h12 = h - 5'd12;
      else                h12 = h;
      v.h_hi = (h12 >= 5'd10) ? 4'd1 : 4'd0;
      v.h_lo = 4'((h12 >= 5'd10) ? (h12 - 5'd10) : h12);
    end
    return {pm_f, v};
  endfunction

  bcd_hms_step u_time_step (
    .val    (time_bcd),
    .down   (1'b0),
    .chk    (wr_bcd),
    .nxt    (time_inc),
    .chk_ok (time_chk_ok)
  );

  bcd_hms_step u_timer_step (
    .val    (timer_bcd),
    .down   (1'b1),
    .chk    (wr_bcd),
    .nxt    (timer_dec),
    .chk_ok (timer_chk_ok)
  );

  assign sec_tick   = (div_cnt == DIV_LAST);
  assign tgt_exists = int'(wr_target) < (NUM_ALARMS + 2);

  assign time_wr  = wr_en && (wr_target == TGT_TIME) && time_chk_ok;
  assign timer_wr = wr_en && (wr_target == TGT_TIMER) && timer_chk_ok && (t_state == T_IDLE);
  assign alarm_wr = wr_en && tgt_exists && (wr_target >= TGT_ALARM0) && time_chk_ok;

  // A time load replaces the tick advance, so a coincident tick is lost.
  assign time_nxt = time_wr ? wr_bcd : (sec_tick ? time_inc : time_bcd);
  assign time_chg = (time_nxt != time_bcd);

  always_comb begin
    alarm_match = '0;
    for (int k = 0; k < NUM_ALARMS; k++) begin
      alarm_match[k] = alarm_en[k] && time_chg && (time_nxt == alarm_q[k]);
    end
  end

  assign timer_hit = (t_state == T_RUN) && sec_tick && (timer_dec == '0);
  assign buzz_evt  = (|alarm_match) || timer_hit;
  assign disp_nxt  = fmt_disp(time_bcd, mode12);

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt    <= '0;
      time_bcd   <= '0;
      timer_bcd  <= '0;
      t_state    <= T_IDLE;
      timer_done <= 1'b0;
      wr_err     <= 1'b0;
      alarm_hit  <= '0;
      buzzer     <= 1'b0;
      buzz_cnt   <= '0;
      disp_bcd   <= '0;
      pm         <= 1'b0;
      for (int k = 0; k < NUM_ALARMS; k++) alarm_q[k] <= '0;
    end else begin
      div_cnt  <= (time_wr || sec_tick) ? '0 : div_cnt + DIV_W'(1);
      time_bcd <= time_nxt;
      wr_err   <= wr_en && !(time_wr || timer_wr || alarm_wr);

      for (int k = 0; k < NUM_ALARMS; k++) begin
        if (alarm_wr && (wr_target == TGT_ALARM0 + 4'(k))) alarm_q[k] <= wr_bcd;
      end

      timer_done <= timer_hit;
      case (t_state)
        T_IDLE: begin
          if (timer_wr) timer_bcd <= wr_bcd;
          else if (timer_start && (timer_bcd != '0)) t_state <= T_RUN;
        end
        T_RUN: begin
          if (sec_tick) begin
            timer_bcd <= timer_dec;
            if (timer_dec == '0) t_state <= T_DONE;
          end
        end
        T_DONE: begin
          if (ack) t_state <= T_IDLE;
        end
        default: t_state <= T_IDLE;
      endcase

      alarm_hit <= ack ? '0 : (alarm_hit | alarm_match);

      // Each new event reloads the full on-time, even while already sounding.
      if (ack) begin
        buzzer   <= 1'b0;
        buzz_cnt <= '0;
      end else if (buzz_evt) begin
        buzzer   <= 1'b1;
        buzz_cnt <= BUZZ_LOAD;
      end else if (buzzer && sec_tick) begin
        buzz_cnt <= buzz_cnt - 8'd1;
        if (buzz_cnt <= 8'd1) buzzer <= 1'b0;
      end

      // stage p1: display view follows time_bcd by one cycle
      {pm, disp_bcd} <= disp_nxt;
    end
  end

endmodule

// File: tb/tb_alarm_timekeeper.sv
// Directed bench for alarm_timekeeper with a short second (TICK_DIV=4),
// two alarm channels and a three-second buzzer.
module tb_alarm_timekeeper;

  localparam int TICK_DIV   = 4;
  localparam int NUM_ALARMS = 2;
  localparam int BUZZ_SECS  = 3;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  wr_en;
  logic [3:0]            wr_target;
  logic [23:0]           wr_bcd;
  logic                  mode12;
  logic [NUM_ALARMS-1:0] alarm_en;
  logic                  timer_start;
  logic                  ack;
  logic [23:0]           time_bcd;
  logic [23:0]           disp_bcd;
  logic                  pm;
  logic [23:0]           timer_bcd;
  logic                  sec_tick;
  logic                  timer_done;
  logic                  wr_err;
  logic                  buzzer;
  logic [NUM_ALARMS-1:0] alarm_hit;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alarm_timekeeper #(
    .TICK_DIV   (TICK_DIV),
    .NUM_ALARMS (NUM_ALARMS),
    .BUZZ_SECS  (BUZZ_SECS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_target   (wr_target),
    .wr_bcd      (wr_bcd),
    .mode12      (mode12),
    .alarm_en    (alarm_en),
    .timer_start (timer_start),
    .ack         (ack),
    .time_bcd    (time_bcd),
    .disp_bcd    (disp_bcd),
    .pm          (pm),
    .timer_bcd   (timer_bcd),
    .sec_tick    (sec_tick),
    .timer_done  (timer_done),
    .wr_err      (wr_err),
    .buzzer      (buzzer),
    .alarm_hit   (alarm_hit)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic write_reg(input logic [3:0] tgt, input logic [23:0] val);
    @(negedge clk);
    wr_en     = 1'b1;
    wr_target = tgt;
    wr_bcd    = val;
    @(negedge clk);
    wr_en     = 1'b0;
  endtask

  task automatic pulse_ack();
    @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    timer_start = 1'b1;
    @(negedge clk);
    timer_start = 1'b0;
  endtask

  // Returns at the negedge just after the n-th observed sec_tick took effect.
  task automatic wait_ticks(input int n);
    int seen   = 0;
    int budget = n * TICK_DIV + 8;
    while (seen < n && budget > 0) begin
      if (sec_tick) seen++;
      if (seen < n) begin
        @(negedge clk);
        budget--;
      end
    end
    check("tick_wait", 32'(seen), 32'(n));
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_target = '0; wr_bcd = '0;
    mode12 = 1'b0; alarm_en = '0; timer_start = 1'b0; ack = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // reset state
    check("rst_time",   32'(time_bcd),  32'h000000);
    check("rst_timer",  32'(timer_bcd), 32'h000000);
    check("rst_disp",   32'(disp_bcd),  32'h000000);
    check("rst_buzzer", 32'(buzzer),    32'd0);
    check("rst_hit",    32'(alarm_hit), 32'd0);
    check("rst_wrerr",  32'(wr_err),    32'd0);

    // midnight rollover
    write_reg(4'd0, 24'h235958);
    check("wr_time",    32'(time_bcd),  32'h235958);
    check("wr_ok",      32'(wr_err),    32'd0);
    wait_ticks(1);
    check("roll_59",    32'(time_bcd),  32'h235959);
    wait_ticks(1);
    check("roll_00",    32'(time_bcd),  32'h000000);

    // rejected writes
    write_reg(4'd0, 24'h101010);
    write_reg(4'd0, 24'h240000);
    check("bad_hour_err",  32'(wr_err),   32'd1);
    check("bad_hour_time", 32'(time_bcd), 32'h101010);
    @(negedge clk);
    check("err_pulse",     32'(wr_err),   32'd0);
    write_reg(4'd0, 24'h101010);
    write_reg(4'd0, 24'h126000);
    check("bad_min_err",   32'(wr_err),   32'd1);
    check("bad_min_time",  32'(time_bcd), 32'h101010);
    write_reg(4'd4, 24'h000000);
    check("bad_tgt_err",   32'(wr_err),   32'd1);

    // alarm channel 1
    write_reg(4'd3, 24'h000005);
    check("alarm_wr_ok", 32'(wr_err), 32'd0);
    alarm_en = 2'b10;
    write_reg(4'd0, 24'h000003);
    wait_ticks(1);
    check("pre_hit",     32'(alarm_hit), 32'd0);
    check("pre_buzz",    32'(buzzer),    32'd0);
    wait_ticks(1);
    check("hit_time",    32'(time_bcd),  32'h000005);
    check("hit_ch1",     32'(alarm_hit), 32'b10);
    check("hit_buzz",    32'(buzzer),    32'd1);
    wait_ticks(2);
    check("buzz_hold",   32'(buzzer),    32'd1);
    wait_ticks(1);
    check("buzz_off",    32'(buzzer),    32'd0);
    check("hit_sticky",  32'(alarm_hit), 32'b10);
    pulse_ack();
    check("ack_hit",     32'(alarm_hit), 32'd0);
    alarm_en = '0;

    // 12-hour display
    mode12 = 1'b1;
    write_reg(4'd0, 24'h003000);
    @(negedge clk);
    check("d12_0030",    32'(disp_bcd), 32'h123000);
    check("pm_0030",     32'(pm),       32'd0);
    write_reg(4'd0, 24'h120000);
    @(negedge clk);
    check("d12_1200",    32'(disp_bcd), 32'h120000);
    check("pm_1200",     32'(pm),       32'd1);
    write_reg(4'd0, 24'h130500);
    @(negedge clk);
    check("d12_1305",    32'(disp_bcd), 32'h010500);
    check("pm_1305",     32'(pm),       32'd1);
    mode12 = 1'b0;
    @(negedge clk);
    check("d24_1305",    32'(disp_bcd), 32'h130500);
    check("pm_24",       32'(pm),       32'd0);

    // countdown timer
    write_reg(4'd1, 24'h000100);
    check("tmr_wr_ok",   32'(wr_err),    32'd0);
    check("tmr_load",    32'(timer_bcd), 32'h000100);
    pulse_start();
    wait_ticks(1);
    check("tmr_0059",    32'(timer_bcd), 32'h000059);
    check("tmr_nodone",  32'(timer_done), 32'd0);
    write_reg(4'd1, 24'h000030);
    check("tmr_run_wr",  32'(wr_err),    32'd1);
    wait_ticks(58);
    check("tmr_0001",    32'(timer_bcd), 32'h000001);
    check("tmr_early",   32'(timer_done), 32'd0);
    wait_ticks(1);
    check("tmr_zero",    32'(timer_bcd), 32'h000000);
    check("tmr_done",    32'(timer_done), 32'd1);
    check("tmr_buzz",    32'(buzzer),    32'd1);
    @(negedge clk);
    check("done_pulse",  32'(timer_done), 32'd0);
    pulse_ack();
    check("ack_buzz",    32'(buzzer),    32'd0);
    check("ack_tmr",     32'(timer_bcd), 32'h000000);
    pulse_start();
    wait_ticks(1);
    check("zero_start",  32'(timer_bcd), 32'h000000);
    check("zero_nodone", 32'(timer_done), 32'd0);
    write_reg(4'd1, 24'h000010);
    check("idle_wr_ok",  32'(wr_err),    32'd0);
    check("idle_load",   32'(timer_bcd), 32'h000010);

    // reset while the timer runs and the buzzer sounds
    pulse_start();
    write_reg(4'd2, 24'h000101);
    alarm_en = 2'b01;
    write_reg(4'd0, 24'h000100);
    wait_ticks(1);
    check("pre_rst_buzz", 32'(buzzer),    32'd1);
    check("pre_rst_hit",  32'(alarm_hit), 32'b01);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    alarm_en = '0;
    check("rst2_time",   32'(time_bcd),   32'h000000);
    check("rst2_timer",  32'(timer_bcd),  32'h000000);
    check("rst2_buzz",   32'(buzzer),     32'd0);
    check("rst2_hit",    32'(alarm_hit),  32'd0);
    check("rst2_done",   32'(timer_done), 32'd0);
    check("rst2_disp",   32'(disp_bcd),   32'h000000);
    check("rst2_tick",   32'(sec_tick),   32'd0);
    write_reg(4'd1, 24'h000005);
    check("rst2_idle",   32'(wr_err),     32'd0);
    check("rst2_tload",  32'(timer_bcd),  32'h000005);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alarm_timekeeper.md
ALARM_TIMEKEEPER -- requirements
Module: alarm_timekeeper

Interface
REQ-001 SHALL have parameter TICK_DIV, default 12000000, clk cycles per second (>=2).
REQ-002 SHALL have parameter NUM_ALARMS, default 4, independent alarm channels (1..8).
REQ-003 SHALL have parameter BUZZ_SECS, default 10, buzzer on-time in seconds (1..255).
REQ-004 SHALL have port clk  in  1  sole clock; rising edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have port wr_en  in  1  one-cycle write strobe.
REQ-007 SHALL have port wr_target  in  4  0=time, 1=timer, 2+k=alarm k.
REQ-008 SHALL have port wr_bcd  in  24  HHMMSS, 6 BCD digits, MSB = hour tens.
REQ-009 SHALL have port mode12  in  1  display in 12-hour format.
REQ-010 SHALL have port alarm_en  in  NUM_ALARMS  per-channel enable.
REQ-011 SHALL have port timer_start  in  1  start countdown.
REQ-012 SHALL have port ack  in  1  silence buzzer, clear hits and timer done.
REQ-013 SHALL have port time_bcd  out  24  current 24-hour time.
REQ-014 SHALL have port disp_bcd  out  24  time in selected format; pm  out  1.
REQ-015 SHALL have port timer_bcd  out  24  countdown value.
REQ-016 SHALL have ports sec_tick, timer_done, wr_err  out  1 each; one-cycle pulses.
REQ-017 SHALL have ports buzzer  out  1; alarm_hit  out  NUM_ALARMS  sticky.

Function
REQ-018 SHALL count divider 0..TICK_DIV-1 and pulse sec_tick on the cycle it wraps.
REQ-019 SHALL advance time_bcd by one second per sec_tick, BCD carry per digit, 23:59:59 wraps to 00:00:00.
REQ-020 SHALL accept a write only if every digit is in range (H<=23, M<=59, S<=59) and target exists; else ignore and pulse wr_err next cycle.
REQ-021 SHALL on accepted time write load time_bcd next cycle and clear the divider; a coincident sec_tick is dropped.
REQ-022 SHALL store alarm k on accepted write; a match is time_bcd becoming equal to alarm k while alarm_en[k]=1 (edge on value change, not level).
REQ-023 SHALL run timer FSM IDLE->RUN on timer_start when timer_bcd!=0; RUN decrements per sec_tick with BCD borrow; reaching 00:00:00 -> DONE and pulses timer_done.
REQ-024 SHALL accept timer writes only in IDLE; writes in RUN/DONE pulse wr_err; timer_start in RUN or with zero value is ignored.
REQ-025 SHALL on ack: DONE->IDLE, timer_bcd retains 0, alarm_hit cleared, buzzer off next cycle; ack wins over a same-cycle new match.
REQ-026 SHALL assert buzzer on any match or timer_done, hold for BUZZ_SECS sec_ticks, restart the count on a new event while sounding.
REQ-027 SHALL set alarm_hit[k] on its match; several channels may set in one cycle.
REQ-028 SHALL register disp_bcd/pm one cycle after time_bcd: mode12=0 -> copy, pm=0; mode12=1 -> hour 00->12 AM, 01-11 AM, 12 PM, 13-23 minus 12 PM.

Reset
REQ-029 SHALL on rst: time 00:00:00, timer 00:00:00 IDLE, all alarms 00:00:00, divider 0, buzzer/pulses/alarm_hit 0, disp_bcd 0, pm 0.
REQ-030 SHALL let rst abort RUN/DONE and a sounding buzzer in the same cycle; rst overrides all inputs.

Structure
REQ-031 SHALL place BCD field widths, wr_target codes and timer state enum in package alarm_timekeeper_pkg.
REQ-032 SHALL implement BCD increment/decrement/validate as one sub-module bcd_hms_step, instantiated for time and timer.

Verification (TICK_DIV=4, NUM_ALARMS=2, BUZZ_SECS=3)
REQ-033 SHALL test: write time 23:59:58 -> after 2 sec_ticks time_bcd=00:00:00.
REQ-034 SHALL test: write 24:00:00 or 12:60:00 -> wr_err pulse, time unchanged.
REQ-035 SHALL test: alarm1=00:00:05 enabled, time 00:00:03 -> alarm_hit=2'b10 and buzzer at 00:00:05, buzzer drops after 3 ticks.
REQ-036 SHALL test: timer 00:01:00, start -> timer_done after 60 ticks, 00:00:59 after first; ack -> IDLE, buzzer 0.
REQ-037 SHALL test: mode12=1, time 00:30:00 -> disp 12:30:00 pm=0; 13:05:00 -> 01:05:00 pm=1.
REQ-038 SHALL test: rst asserted mid-RUN with buzzer on -> all outputs at reset values next cycle.
